// File: rtl/dpram_pkg.sv
// Shared constants and helpers for the true dual-port RAM.
// Word widths up to MaxWidth bits are supported by the byte-merge helper.
package dpram_pkg;

  localparam int unsigned WM_READ_FIRST  = 0;
  localparam int unsigned WM_WRITE_FIRST = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  localparam int unsigned MaxBytes = 16;
  localparam int unsigned MaxWidth = MaxBytes * 8;

  // Replace the bytes of old_word selected by we with the matching bytes of new_word.
  function automatic logic [MaxWidth-1:0] byte_merge(input logic [MaxWidth-1:0] old_word,
                                                     input logic [MaxWidth-1:0] new_word,
                                                     input logic [MaxBytes-1:0] we);
    logic [MaxWidth-1:0] res;
    res = old_word;
    for (int i = 0; i < MaxBytes; i++) begin
      if (we[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_out_stage.sv
// Per-port read path: write-mode data selection, optional second register
// stage and the read-valid strobe that travels with the data.
module dpram_out_stage
  import dpram_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned WRITE_MODE = 0,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] rd_word,
  input  logic [WIDTH-1:0] wr_word,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  logic             capture;
  logic [WIDTH-1:0] s1_data_d, s1_data_q;
  logic             s1_valid_q;

  // A NO_CHANGE write leaves the stage untouched and produces no strobe.
  always_comb begin
    capture   = en && !(wr && (WRITE_MODE == WM_NO_CHANGE));
    s1_data_d = s1_data_q;
    if (capture) begin
      s1_data_d = (wr && (WRITE_MODE == WM_WRITE_FIRST)) ? wr_word : rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= capture;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] s2_data_d, s2_data_q;
    logic             s2_valid_q;

    always_comb begin
      s2_data_d = s2_data_q;
      if (s1_valid_q) s2_data_d = s1_data_q;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_data_q  <= s2_data_d;
        s2_valid_q <= s1_valid_q;
      end
    end

    assign dout       = s2_data_q;
    assign dout_valid = s2_valid_q;
  end else begin : g_no_out_reg
    assign dout       = s1_data_q;
    assign dout_valid = s1_valid_q;
  end

endmodule

// File: rtl/dualport_ram.sv
// True dual-port RAM on a single clock with byte enables, selectable
// read-during-write mode and optional output register per port.
module dualport_ram
  import dpram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = 16,
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter int unsigned LOG_DEPTH  = 10,
  parameter int unsigned WRITE_MODE = 0,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [RAM_WIDTH/8-1:0] wea,
  input  logic [LOG_DEPTH-1:0]   addra,
  input  logic [RAM_WIDTH-1:0]   dina,
  output logic [RAM_WIDTH-1:0]   douta,
  output logic                   douta_valid,
  input  logic                   enb,
  input  logic [RAM_WIDTH/8-1:0] web,
  input  logic [LOG_DEPTH-1:0]   addrb,
  input  logic [RAM_WIDTH-1:0]   dinb,
  output logic [RAM_WIDTH-1:0]   doutb,
  output logic                   doutb_valid
);

  localparam int unsigned NumBytes = RAM_WIDTH / 8;
  localparam logic [LOG_DEPTH:0] DepthLim = (LOG_DEPTH + 1)'(RAM_DEPTH);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic                 in_range_a, in_range_b;
  logic                 wr_cyc_a, wr_cyc_b;
  logic                 commit_a, commit_b;
  logic [RAM_WIDTH-1:0] old_a, old_b;
  logic [RAM_WIDTH-1:0] merged_a, merged_b;
  logic [MaxWidth-1:0]  merged_a_wide, merged_b_wide;

  assign in_range_a = {1'b0, addra} < DepthLim;
  assign in_range_b = {1'b0, addrb} < DepthLim;
  assign wr_cyc_a   = ena && (|wea);
  assign wr_cyc_b   = enb && (|web);
  assign commit_a   = wr_cyc_a && in_range_a;
  assign commit_b   = wr_cyc_b && in_range_b;

  // Both ports see the pre-edge contents, so a cross-port reader always gets the old word.
  assign old_a = in_range_a ? mem[addra] : '0;
  assign old_b = in_range_b ? mem[addrb] : '0;

  always_comb begin
    merged_a_wide = byte_merge(MaxWidth'(old_a), MaxWidth'(dina), MaxBytes'(wea));
    merged_b_wide = byte_merge(MaxWidth'(old_b), MaxWidth'(dinb), MaxBytes'(web));
    merged_a      = in_range_a ? merged_a_wide[RAM_WIDTH-1:0] : '0;
    merged_b      = in_range_b ? merged_b_wide[RAM_WIDTH-1:0] : '0;
  end

  // Port A lanes are written after port B so A wins any overlapping lane.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (commit_b && web[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
      end
      for (int i = 0; i < NumBytes; i++) begin
        if (commit_a && wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

  dpram_out_stage #(
    .WIDTH      (RAM_WIDTH),
    .WRITE_MODE (WRITE_MODE),
    .OUT_REG    (OUT_REG)
  ) u_out_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (ena),
    .wr         (wr_cyc_a),
    .rd_word    (old_a),
    .wr_word    (merged_a),
    .dout       (douta),
    .dout_valid (douta_valid)
  );

  dpram_out_stage #(
    .WIDTH      (RAM_WIDTH),
    .WRITE_MODE (WRITE_MODE),
    .OUT_REG    (OUT_REG)
  ) u_out_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (enb),
    .wr         (wr_cyc_b),
    .rd_word    (old_b),
    .wr_word    (merged_b),
    .dout       (doutb),
    .dout_valid (doutb_valid)
  );

endmodule

// File: doc/dualport_ram.md
Name: dualport_ram

Overview:
- Parametrised true dual-port block RAM; successor to the single-port RAM used across the design.
- Two independent read/write ports (A, B) on one clock, with:
  - per-byte write enables;
  - selectable write mode (read-first / write-first / no-change);
  - optional output register stage;
  - a read-valid strobe per port.
- Used as shared buffer memory between two producers/consumers, e.g. DMA side vs. processing side.

Parameters:
- RAM_WIDTH, 16, data word width in bits; must be a multiple of 8.
- RAM_DEPTH, 1024, number of words.
- LOG_DEPTH, 10, address width; RAM_DEPTH <= 2**LOG_DEPTH.
- WRITE_MODE, 0, same-port read-during-write behaviour: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.

Ports:
- clk  input  1  Rising-edge clock for both ports.
- rst_n  input  1  Synchronous active-low reset.
- ena  input  1  Port A enable; no access when low.
- wea  input  RAM_WIDTH/8  Port A byte write enables; bit i writes dina[8i+7:8i].
- addra  input  LOG_DEPTH  Port A address.
- dina  input  RAM_WIDTH  Port A write data.
- douta  output  RAM_WIDTH  Port A read data.
- douta_valid  output  1  Port A read data valid, one cycle per completed read.
- enb, web, addrb, dinb, doutb, doutb_valid: Port B equivalents, same widths and meanings.

Behaviour:
- Reset (rst_n low at a rising edge): clears douta, doutb, both valids, and all pipeline registers to 0. Memory contents are not cleared. Reset has priority over all accesses; no writes commit in a reset cycle.
- Access: an edge with en=1 accesses mem[addr]. Any we bit set makes it a write; bytes with we bit 0 keep their old value.
- Read cycle (en=1, we=0): data appears on dout after the edge (OUT_REG=0), or one edge later (OUT_REG=1). dout_valid is coincident with the data for one cycle.
- Write cycle (en=1, we!=0), depending on WRITE_MODE:
  - READ_FIRST: dout gets the old word; valid asserts.
  - WRITE_FIRST: dout gets the merged new word (old bytes where we=0); valid asserts.
  - NO_CHANGE: dout and the stage-1 register hold their values; valid does not assert.
- en=0: dout holds its last value; valid deasserts (stage-1 valid is 0 and shifts through with OUT_REG=1).
- Pipelining: with OUT_REG=1 the pipeline accepts a new access every cycle. Throughput is 1 access per port per cycle.
- Cross-port collisions (same address, same edge):
  - Both ports writing: port A bytes win on overlapping byte lanes. Port B bytes land on lanes only B enables.
  - One port writes, the other reads: the reader gets the old word, independent of WRITE_MODE.
- Address >= RAM_DEPTH: writes are ignored. Reads return 0, with valid asserted as usual.
- Reset mid-operation with OUT_REG=1: in-flight stage data is discarded. The first valid after reset requires a fresh access.

Decomposition:
- Package dpram_pkg holds:
  - WRITE_MODE constants: WM_READ_FIRST=0, WM_WRITE_FIRST=1, WM_NO_CHANGE=2;
  - a function computing byte-merged write data (old, new, we).
- Sub-module dpram_out_stage, instantiated once per port: handles write-mode selection, optional output register, and valid generation.
- The top level owns the shared memory array and the collision resolution.

Test Plan (RAM_WIDTH=16, OUT_REG=0 unless noted):
1. Port A writes 16'hAAAA @0x000 with wea=2'b11, then Port B reads 0x000 → doutb=16'hAAAA with doutb_valid=1 one cycle after the read edge; douta_valid=0 throughout the idle cycles.
2. With mem[5]=16'h1234, Port A writes 16'hABCD to addr 5 with wea=2'b01; dout observed on that write cycle, per mode:
   - READ_FIRST: douta=16'h1234;
   - WRITE_FIRST: douta=16'h12CD;
   - NO_CHANGE: douta holds its prior value and douta_valid=0.
   - A following read of addr 5 returns 16'h12CD in all modes.
3. Same edge, addr 7 (mem[7]=16'h0000): A writes 16'h1111 with wea=2'b10, B writes 16'h2222 with web=2'b11 → mem[7]=16'h1122. A separate run where B reads addr 7 while A writes returns the old word 16'h0000.
4. OUT_REG=1: back-to-back reads on port A of addresses 0,1,2 holding 16'h00AA, 16'h00BB, 16'h00CC → douta shows them on edges 2, 3, 4 with douta_valid high for exactly 3 consecutive cycles.
5. OUT_REG=1, read of addr 1 issued, then rst_n=0 on the next edge → douta=0 and douta_valid=0 after reset; mem[1] is still 16'h00BB on a re-read.
6. Write to addr 1023 with 16'hBEEF, then read → 16'hBEEF (top-of-range address). With RAM_DEPTH=1000, a write to addr 1010 is ignored and a read of it returns 16'h0000 with valid=1.
